// File: rtl/collision_arbiter.sv
// Two-requester arbiter around a shared wall-map lookup: checks the four sprite corners
// one per clock and returns a registered collision vector with a one-cycle ack.
// Define FIXED_PRIO_EN to make requester 0 always win ties (no round-robin pointer).
module collision_arbiter #(
    parameter int MAP_COLS   = 15,
    parameter int MAP_ROWS   = 10,
    parameter int CELL_SHIFT = 6,
    parameter int SPRITE_W   = 48,
    parameter int SPRITE_H   = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAP_COLS*MAP_ROWS-1:0] map,
    input  logic [1:0]                   req,
    input  logic [11:0]                  req_x0,
    input  logic [11:0]                  req_y0,
    input  logic [11:0]                  req_x1,
    input  logic [11:0]                  req_y1,
    output logic [1:0]                   ack,
    output logic [3:0]                   collision,
    output logic                         hit,
    output logic                         busy
);
    localparam int NCELL = MAP_COLS * MAP_ROWS;
    localparam int IW    = $clog2(NCELL);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CHK0 = 3'd1;
    localparam logic [2:0] ST_CHK1 = 3'd2;
    localparam logic [2:0] ST_CHK2 = 3'd3;
    localparam logic [2:0] ST_CHK3 = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        win_q, win_d;
    logic [2:0]  res_q, res_d;
    logic [1:0]  ack_q, ack_d;
    logic [3:0]  coll_q, coll_d;
    logic        hit_q, hit_d;
    logic        gnt;

    // Corner geometry for the current CHK state
    logic        off_x, off_y;
    logic [12:0] cx, cy, col, row;
    logic [IW-1:0] lin, bit_idx;
    logic        oob, cell_hit;

    always_comb begin
        off_x = 1'b0;
        off_y = 1'b0;
        case (state_q)
            ST_CHK1: off_x = 1'b1;
            ST_CHK2: off_y = 1'b1;
            ST_CHK3: begin
                off_x = 1'b1;
                off_y = 1'b1;
            end
            default: ;
        endcase
    end

    // 13-bit sums so a carry past 4095 is visible and counts as out of bounds
    assign cx  = {1'b0, x_q} + (off_x ? 13'(SPRITE_W - 1) : 13'd0);
    assign cy  = {1'b0, y_q} + (off_y ? 13'(SPRITE_H - 1) : 13'd0);
    assign col = cx >> CELL_SHIFT;
    assign row = cy >> CELL_SHIFT;
    assign oob = cx[12] | cy[12] | (col >= 13'(MAP_COLS)) | (row >= 13'(MAP_ROWS));

    // Cell index only meaningful when in bounds; oob masks any wrapped value
    assign lin      = IW'(row) * IW'(MAP_COLS) + IW'(col);
    assign bit_idx  = IW'(NCELL - 1) - lin;
    assign cell_hit = oob | map[bit_idx];

`ifdef FIXED_PRIO_EN
    assign gnt = ~req[0];
`else
    logic rr_q, rr_d;

    // rr_q names the requester that wins a tie
    assign gnt = (req == 2'b11) ? rr_q : req[1];

    always_comb begin
        rr_d = rr_q;
        if (state_q == ST_IDLE && req != 2'b00)
            rr_d = ~gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_q <= 1'b0;
        else      rr_q <= rr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        win_d   = win_q;
        res_d   = res_q;
        ack_d   = 2'b00;
        coll_d  = coll_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    win_d   = gnt;
                    x_d     = gnt ? req_x1 : req_x0;
                    y_d     = gnt ? req_y1 : req_y0;
                    state_d = ST_CHK0;
                end
            end
            ST_CHK0: begin
                res_d[0] = cell_hit;
                state_d  = ST_CHK1;
            end
            ST_CHK1: begin
                res_d[1] = cell_hit;
                state_d  = ST_CHK2;
            end
            ST_CHK2: begin
                res_d[2] = cell_hit;
                state_d  = ST_CHK3;
            end
            ST_CHK3: begin
                coll_d  = {cell_hit, res_q};
                hit_d   = cell_hit | (|res_q);
                ack_d   = win_q ? 2'b10 : 2'b01;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= 1'b0;
            res_q   <= '0;
            ack_q   <= '0;
            coll_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            win_q   <= win_d;
            res_q   <= res_d;
            ack_q   <= ack_d;
            coll_q  <= coll_d;
            hit_q   <= hit_d;
        end
    end

    assign ack       = ack_q;
    assign collision = coll_q;
    assign hit       = hit_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter: expected acks/collisions queued at request time,
// compared (including latency) when the DUT acks.
module tb_collision_arbiter;
    localparam int NC = 15, NR = 10, NCELL = NC * NR;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NCELL-1:0] map_r = '0;
    logic [1:0]       req = 2'b00;
    logic [11:0]      x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [1:0]       ack;
    logic [3:0]       coll;
    logic             hit, busy;

    collision_arbiter dut (
        .clk(clk), .rst(rst), .map(map_r), .req(req),
        .req_x0(x0), .req_y0(y0), .req_x1(x1), .req_y1(y1),
        .ack(ack), .collision(coll), .hit(hit), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0] ack;
        logic [3:0] coll;
        int         at_cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0, n_bad = 0;
    logic [3:0] last_coll = '0;
    logic [1:0] ack_prev = '0;
    bit         rr_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input int x, input int y, input logic [NCELL-1:0] m);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            int cx, cy, c, r;
            cx = x + (((k & 1) != 0) ? 47 : 0);
            cy = y + (((k & 2) != 0) ? 47 : 0);
            c  = cx / 64;
            r  = cy / 64;
            if (cx >= 4096 || cy >= 4096 || c >= NC || r >= NR) v[k] = 1'b1;
            else                                                  v[k] = m[NCELL-1-(r*NC+c)];
        end
        return v;
    endfunction

    // Monitor: compare each ack against the scoreboard; requester drops req on ack
    always @(negedge clk) begin
        if (rst) begin
            if (ack_prev != 2'b00) chk("ack_width", {30'd0, ack}, 32'd0);
            if (ack != 2'b00) begin
                if (sb.size() == 0) chk("spurious_ack", {30'd0, ack}, 32'd0);
                else begin
                    exp_t it;
                    it = sb.pop_front();
                    chk("ack", {30'd0, ack}, {30'd0, it.ack});
                    chk("collision", {28'd0, coll}, {28'd0, it.coll});
                    chk("hit", {31'd0, hit}, {31'd0, |it.coll});
                    chk("latency", cyc, it.at_cyc);
                    last_coll = it.coll;
                end
                req = req & ~ack;
            end
        end
        ack_prev = rst ? ack : 2'b00;
    end

    task automatic push(input bit w, input int at, input logic [11:0] ax0, ay0, ax1, ay1);
        exp_t it;
        it.ack    = w ? 2'b10 : 2'b01;
        it.coll   = model(w ? int'(ax1) : int'(ax0), w ? int'(ay1) : int'(ay0), map_r);
        it.at_cyc = at;
        sb.push_back(it);
    endtask

    task automatic do_req(input logic [1:0] m, input logic [11:0] ax0, ay0, ax1, ay1);
        int e0, n;
        bit w;
        @(negedge clk); #1;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        req = m;
        e0 = cyc + 1;
        if (m == 2'b11) begin
`ifdef FIXED_PRIO_EN
            w = 1'b0;
`else
            w = rr_m;
`endif
            push(w, e0 + 4, ax0, ay0, ax1, ay1);
            push(~w, e0 + 10, ax0, ay0, ax1, ay1);
        end else begin
            w = m[1];
            push(w, e0 + 4, ax0, ay0, ax1, ay1);
            rr_m = ~w;
        end
        @(posedge clk); #1;
        chk("busy_run", {31'd0, busy}, 32'd1);
        if (m != 2'b11) begin
            // coordinates are latched at the grant; later changes must not matter
            @(posedge clk); #1;
            x0 = 12'($urandom); y0 = 12'($urandom);
            x1 = 12'($urandom); y1 = 12'($urandom);
        end
        n = 0;
        while (req != 2'b00 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (req != 2'b00) begin
            chk("ack_timeout", {30'd0, req}, 32'd0);
            req = 2'b00;
            sb.delete();
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("hold_coll", {28'd0, coll}, {28'd0, last_coll});
        chk("hold_hit", {31'd0, hit}, {31'd0, |last_coll});
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requests high: outputs must stay quiet
        req = 2'b11;
        repeat (4) begin
            @(negedge clk);
            chk("rst_ack", {30'd0, ack}, 32'd0);
            chk("rst_coll", {28'd0, coll}, 32'd0);
            chk("rst_hit", {31'd0, hit}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        req = 2'b00;
        #1 rst = 1'b1;

        // First tie after reset goes to requester 0
        do_req(2'b11, 12'd100, 12'd100, 12'd940, 12'd0);

        // Clear map, in-bounds sprite
        do_req(2'b01, 12'd100, 12'd100, 12'd0, 12'd0);

        // Single wall at row 1, col 2 (bit 132)
        map_r = '0;
        map_r[132] = 1'b1;
        do_req(2'b01, 12'd100, 12'd40, 12'd0, 12'd0);

        // Right edge past column 14, then 13-bit overflow
        map_r = '0;
        do_req(2'b10, 12'd0, 12'd0, 12'd940, 12'd0);
        do_req(2'b10, 12'd0, 12'd0, 12'd4090, 12'd0);

        // Reset while in CHK2: check discarded, outputs cleared
        @(negedge clk); #1;
        x0 = 12'd100; y0 = 12'd100; req = 2'b01;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ack", {30'd0, ack}, 32'd0);
        chk("mid_rst_coll", {28'd0, coll}, 32'd0);
        chk("mid_rst_hit", {31'd0, hit}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        req = 2'b00;
        rr_m = 1'b0;
        last_coll = '0;
        @(negedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        map_r[NCELL-1] = 1'b1;
        do_req(2'b01, 12'd0, 12'd0, 12'd0, 12'd0);

        // Arbitration: lone req[1], then both held
        map_r = '0;
        map_r[NCELL-1-(2*NC+3)] = 1'b1;
        do_req(2'b10, 12'd0, 12'd0, 12'd200, 12'd130);
        do_req(2'b11, 12'd10, 12'd20, 12'd900, 12'd600);
        do_req(2'b11, 12'd180, 12'd100, 12'd200, 12'd100);

        // Random maps and positions, mixing in- and out-of-bounds
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NCELL; i++) map_r[i] = 1'($urandom_range(0, 1));
            do_req(2'($urandom_range(1, 3)),
                   12'($urandom_range(0, 1100)), 12'($urandom_range(0, 700)),
                   12'($urandom_range(0, 1100)), 12'($urandom_range(0, 700)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
